vga_text_gen: RTL and testbench

VGA_TEXT_GEN -- requirements
Module: vga_text_gen

---
 rtl/vga_text_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_vga_text_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_gen.sv
// -----------------------------------------------------------------------------
// vga_text_gen
// 80x60 character text-mode pixel generator for a 640x480 VGA raster.
//
// The text buffer holds one 7-bit code per cell, addressed row*80+col. The
// display path is a 3-stage pipeline: buffer read, font ROM read, pixel select.
// After reset, or on a clr pulse, a clear sequence writes CLEAR_CHAR to every
// cell, one cell per cycle, while the write port is held off and pixel is 0.
//
// Optional feature: define VGA_TEXT_CURSOR_EN to add a blinking block cursor.
// Without it the cursor ports are present but ignored.
//
// Ports
//   clk                    25 MHz pixel clock, rising edge
//   rst                    asynchronous active-high reset
//   hcount, vcount         raster position (0..799, 0..519)
//   clr                    single-cycle request to blank the buffer
//   wr_valid / wr_ready    character write handshake
//   wr_col, wr_row, wr_char  write cell and code
//   cursor_col, cursor_row cursor cell
//   pixel                  monochrome pixel, aligned with hcount_out/vcount_out
//   hcount_out, vcount_out hcount/vcount delayed by 3 cycles
// -----------------------------------------------------------------------------
module vga_text_gen #(
    parameter logic [6:0] CLEAR_CHAR   = 7'h20,
    parameter int         BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       clr,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_col,
    input  logic [5:0] wr_row,
    input  logic [6:0] wr_char,
    input  logic [6:0] cursor_col,
    input  logic [5:0] cursor_row,
    output logic       pixel,
    output logic [9:0] hcount_out,
    output logic [9:0] vcount_out
);

    localparam int          CELLS     = 4800;
    localparam logic [12:0] LAST_ADDR = 13'd4799;

    typedef enum logic {CLEAR, RUN} state_t;

    // ------------------------------------------------------------------
    // Control FSM: clear sequencer and write-port ready
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [12:0] clr_addr_q, clr_addr_d;
    logic        wr_ready_q, wr_ready_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ready_d = wr_ready_q;
        case (state_q)
            CLEAR: begin
                if (clr) begin
                    clr_addr_d = 13'd0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = RUN;
                    clr_addr_d = 13'd0;
                    wr_ready_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 13'd1;
                end
            end
            RUN: begin
                // A write presented in the same cycle is still stored this
                // edge; the clear that follows then overwrites it.
                if (clr) begin
                    state_d    = CLEAR;
                    clr_addr_d = 13'd0;
                    wr_ready_d = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= 13'd0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign wr_ready = wr_ready_q;

    // ------------------------------------------------------------------
    // Text buffer: one write port (clear or host), one display read port
    // ------------------------------------------------------------------
    logic [6:0]  text_mem [0:CELLS-1];
    logic        mem_we;
    logic [12:0] mem_waddr;
    logic [6:0]  mem_wdata;
    logic [12:0] rd_addr;
    logic [12:0] rd_addr_safe;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = 13'(wr_row) * 13'd80 + 13'(wr_col);
        mem_wdata = wr_char;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = CLEAR_CHAR;
        end else if (wr_valid && (wr_col < 7'd80) && (wr_row < 6'd60)) begin
            // Out-of-range cells complete the handshake but are dropped
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            text_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Blanking-region positions can form addresses past the buffer; they are
    // redirected to cell 0 since their pixels are forced to 0 anyway.
    assign rd_addr      = 13'(vcount[8:3]) * 13'd80 + 13'(hcount[9:3]);
    assign rd_addr_safe = (rd_addr < 13'd4800) ? rd_addr : 13'd0;

    // ------------------------------------------------------------------
    // Font ROM: bit 7 of each row is the leftmost pixel
    // ------------------------------------------------------------------
    function automatic logic [7:0] font_row(input logic [6:0] code, input logic [2:0] row);
        logic [7:0][7:0] glyph;   // glyph[7] is row 0
        case (code)
            7'h20:   glyph = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            7'h41:   glyph = {8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
            7'h42:   glyph = {8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00};
            7'h48:   glyph = {8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
            // Codes without a drawn glyph show a hollow box
            default: glyph = {8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
        endcase
        return glyph[3'd7 - row];
    endfunction

    // ------------------------------------------------------------------
    // Display pipeline
    // ------------------------------------------------------------------
    logic [6:0] char_q;
    logic [9:0] h1_q, h1_d, v1_q, v1_d;
    logic [9:0] h2_q, h2_d, v2_q, v2_d;
    logic [7:0] font_q, font_d;
    logic       pixel_q, pixel_d;
    logic [9:0] hout_q, hout_d, vout_q, vout_d;
    logic       active;
    logic       font_bit;
    logic       cursor_hit;

`ifdef VGA_TEXT_CURSOR_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Each frame start bumps the count; the phase flips on the frame start
    // that would take the count past BLINK_FRAMES.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (hcount == 10'd0 && vcount == 10'd0) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES)) begin
                blink_d     = ~blink_q;
                blink_cnt_d = BW'(1);
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign cursor_hit = blink_q && (h2_q[9:3] == cursor_col) && (v2_q[8:3] == cursor_row);
`else
    wire unused_cursor = ^{cursor_col, cursor_row} ^ (BLINK_FRAMES == 0);
    assign cursor_hit = 1'b0;
`endif

    assign active   = (h2_q < 10'd640) && (v2_q < 10'd480);
    assign font_bit = font_q[3'd7 - h2_q[2:0]];

    always_comb begin
        h1_d    = hcount;
        v1_d    = vcount;
        h2_d    = h1_q;
        v2_d    = v1_q;
        font_d  = font_row(char_q, v1_q[2:0]);
        hout_d  = h2_q;
        vout_d  = v2_q;
        pixel_d = (state_q == RUN) && active && (font_bit ^ cursor_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q  <= 7'd0;
            h1_q    <= 10'd0;
            v1_q    <= 10'd0;
            h2_q    <= 10'd0;
            v2_q    <= 10'd0;
            font_q  <= 8'd0;
            hout_q  <= 10'd0;
            vout_q  <= 10'd0;
            pixel_q <= 1'b0;
        end else begin
            char_q  <= text_mem[rd_addr_safe];
            h1_q    <= h1_d;
            v1_q    <= v1_d;
            h2_q    <= h2_d;
            v2_q    <= v2_d;
            font_q  <= font_d;
            hout_q  <= hout_d;
            vout_q  <= vout_d;
            pixel_q <= pixel_d;
        end
    end

    assign pixel      = pixel_q;
    assign hcount_out = hout_q;
    assign vcount_out = vout_q;

endmodule

// File: tb/tb_vga_text_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_text_gen
// Randomized self-checking bench for vga_text_gen. A behavioural model holds the
// 80x60 buffer as a plain array and renders each raster position from glyph
// bitmaps; expected pixels travel through a 3-entry queue to match the latency.
// Clear sequences are timed by counting cycles until wr_ready rises.
// -----------------------------------------------------------------------------
module tb_vga_text_gen;

    localparam int TB_BLINK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hcount, vcount;
    logic       clr;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_col;
    logic [5:0] wr_row;
    logic [6:0] wr_char;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic       pixel;
    logic [9:0] hcount_out, vcount_out;

    always #20 clk = ~clk;

    vga_text_gen #(.CLEAR_CHAR(7'h20), .BLINK_FRAMES(TB_BLINK)) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .pixel(pixel), .hcount_out(hcount_out), .vcount_out(vcount_out)
    );

    int         total = 0;
    int         bad   = 0;
    logic [6:0] model_mem [4800];
    int         frames_started = 0;
    int         qh[$];
    int         qv[$];
    logic       qp[$];
    int         wcol[$];
    int         wrow[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] glyph_row(input logic [6:0] c, input int r);
        logic [63:0] g;
        case (c)
            7'h20:   g = 64'h0000000000000000;
            7'h41:   g = 64'h183C66667E666600;
            7'h42:   g = 64'h7C66667C66667C00;
            7'h48:   g = 64'h6666667E66666600;
            default: g = 64'hFF818181818181FF;
        endcase
        return g[63 - 8*r -: 8];
    endfunction

    function automatic logic exp_pixel(input int h, input int v);
        logic [7:0] row_bits;
        logic       b;
        if (h > 639 || v > 479) return 1'b0;
        row_bits = glyph_row(model_mem[(v / 8) * 80 + h / 8], v % 8);
        b = row_bits[7 - (h % 8)];
`ifdef VGA_TEXT_CURSOR_EN
        if (frames_started > 0 && (((frames_started - 1) / TB_BLINK) % 2) == 1 &&
            h / 8 == int'(cursor_col) && v / 8 == int'(cursor_row))
            b = ~b;
`endif
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4800; i++) model_mem[i] = 7'h20;
    endtask

    // ---------------- raster stepping ----------------
    task automatic step(input int h, input int v);
        int   eh, ev;
        logic ep;
        @(negedge clk);
        if (qh.size() == 3) begin
            eh = qh.pop_front();
            ev = qv.pop_front();
            ep = qp.pop_front();
            check($sformatf("pixel@%0d,%0d", eh, ev), 32'(pixel), 32'(ep));
            check("hcount_out", 32'(hcount_out), 32'(eh));
            check("vcount_out", 32'(vcount_out), 32'(ev));
        end
`ifdef VGA_TEXT_CURSOR_EN
        if (h == 0 && v == 0) frames_started++;
`endif
        hcount = 10'(h);
        vcount = 10'(v);
        qh.push_back(h);
        qv.push_back(v);
        qp.push_back(exp_pixel(h, v));
    endtask

    task automatic scan_begin();
        qh.delete(); qv.delete(); qp.delete();
    endtask

    task automatic scan_end();
        repeat (3) step(700, 500);
        qh.delete(); qv.delete(); qp.delete();
    endtask

    task automatic scan_cell(input int col, input int row);
        scan_begin();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                step(col * 8 + x, row * 8 + y);
        scan_end();
        $display("scan cell col=%0d row=%0d", col, row);
    endtask

    task automatic scan_random(input int n);
        int h, v, k;
        scan_begin();
        for (int i = 0; i < n; i++) begin
            if (wcol.size() > 0 && $urandom_range(0, 9) < 7) begin
                k = $urandom_range(0, wcol.size() - 1);
                h = wcol[k] * 8 + $urandom_range(0, 7);
                v = wrow[k] * 8 + $urandom_range(0, 7);
            end else begin
                h = $urandom_range(0, 799);
                v = $urandom_range(0, 519);
            end
            step(h, v);
        end
        scan_end();
        $display("scan random n=%0d", n);
    endtask

    // ---------------- write and clear helpers ----------------
    task automatic do_write(input int col, input int row, input logic [6:0] ch, input logic with_clr);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 6'(row);
        wr_char  = ch;
        clr      = with_clr;
        while (!wr_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) check("wr_handshake_timeout", 32'd1, 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        clr      = 1'b0;
        if (col < 80 && row < 60) begin
            model_mem[row * 80 + col] = ch;
            wcol.push_back(col);
            wrow.push_back(row);
        end
        if (with_clr) model_clear();
        $display("write col=%0d row=%0d char=%02h clr=%0d", col, row, ch, with_clr);
    endtask

    // Count cycles while a clear runs; pixel must stay 0. The raster points at
    // cell (79,59), the last one overwritten, so stale glyphs would show.
    task automatic clear_wait(input string tag);
        int n = 0;
        while (n < 6000) begin
            @(negedge clk);
            n++;
            if (wr_ready) break;
            check("pixel_in_clear", 32'(pixel), 32'd0);
            hcount = 10'(632 + $urandom_range(0, 7));
            vcount = 10'(472 + $urandom_range(0, 7));
        end
        check(tag, 32'(n), 32'd4800);
        $display("clear %s cycles=%0d", tag, n);
    endtask

    task automatic hold_clear(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ready_in_clear", 32'(wr_ready), 32'd0);
            check("pixel_in_clear", 32'(pixel), 32'd0);
            hcount = 10'(632 + $urandom_range(0, 7));
            vcount = 10'(472 + $urandom_range(0, 7));
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        $display("clr pulse");
    endtask

    logic [6:0] rnd_char;
    logic [6:0] pick_chars [5];

    initial begin
        pick_chars[0] = 7'h41; pick_chars[1] = 7'h42; pick_chars[2] = 7'h48;
        pick_chars[3] = 7'h20; pick_chars[4] = 7'h00;
        rst = 1'b1; hcount = 10'd123; vcount = 10'd45; clr = 1'b0;
        wr_valid = 1'b0; wr_col = 7'd0; wr_row = 6'd0; wr_char = 7'd0;
        cursor_col = 7'd127; cursor_row = 6'd63;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_hcount_out", 32'(hcount_out), 32'd0);
        check("rst_vcount_out", 32'(vcount_out), 32'd0);

        // Clear after reset release; every cell must read as a space
        rst = 1'b0;
        model_clear();
        clear_wait("clear_after_reset");
        scan_random(1200);

        // 'A' at the origin, scanned in raster order
        do_write(0, 0, 7'h41, 1'b0);
        scan_begin();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                step(x, y);
        scan_end();
        $display("scan glyph A at origin");

        // Random writes followed by a biased random scan
        for (int i = 0; i < 24; i++) begin
            rnd_char = ($urandom_range(0, 5) == 5) ? 7'($urandom_range(0, 127))
                                                   : pick_chars[$urandom_range(0, 4)];
            do_write($urandom_range(0, 79), $urandom_range(0, 59), rnd_char, 1'b0);
        end
        scan_random(1500);

        // Out-of-range writes complete but leave the buffer untouched
        do_write(0, 6, 7'h48, 1'b0);
        do_write(80, 5, 7'h42, 1'b0);
        do_write(3, 60, 7'h42, 1'b0);
        do_write(127, 63, 7'h42, 1'b0);
        scan_cell(0, 6);
        scan_cell(3, 59);
        scan_cell(79, 5);

        // Write and clr together: write accepted, then a full clear
        do_write(79, 59, 7'h41, 1'b0);
        do_write(5, 5, 7'h42, 1'b1);
        check("ready_after_clr", 32'(wr_ready), 32'd0);
        clear_wait("clear_after_write_clr");
        scan_cell(5, 5);
        scan_cell(79, 59);

        // clr during a clear restarts it from address 0
        do_write(79, 59, 7'h41, 1'b0);
        pulse_clr();
        hold_clear(1000);
        pulse_clr();
        model_clear();
        clear_wait("clear_restart");
        scan_cell(79, 59);

        // Reset in the middle of a clear
        do_write(79, 59, 7'h41, 1'b0);
        pulse_clr();
        hold_clear(2000);
        rst = 1'b1;
        #5;
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        check("midrst_pixel", 32'(pixel), 32'd0);
        check("midrst_hcount_out", 32'(hcount_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frames_started = 0;
        model_clear();
        clear_wait("clear_after_midrst");

`ifdef VGA_TEXT_CURSOR_EN
        // Blinking cursor at (1,1) on a space
        cursor_col = 7'd1;
        cursor_row = 6'd1;
        for (int f = 0; f < 6; f++) begin
            scan_begin();
            step(0, 0);
            repeat (3) step(700, 500);
            for (int y = 8; y < 16; y++)
                for (int x = 8; x < 24; x++)
                    step(x, y);
            scan_end();
            $display("cursor frame %0d", f);
        end
        cursor_col = 7'd127;
        cursor_row = 6'd63;
`endif

        scan_cell(79, 59);
        scan_random(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
